// File: rtl/reorder_buffer_commit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : reorder_buffer_commit                                    |
// | Description : In-order retirement queue. Rename allocates entries at   |
// |               the tail, CDB writebacks mark them ready, and the head   |
// |               entry retires in program order. A retiring mispredicted |
// |               branch raises the flush output and empties the buffer.  |
// | Option      : ROB_CDB_BYPASS_EN lets a CDB write to the valid head     |
// |               entry commit in the same cycle as the writeback.        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module reorder_buffer_commit #(
  parameter int ROB   = 2,
  parameter int REG   = 4,
  parameter int WIDTH = 31
) (
  input  logic           clk,
  input  logic           globalReset,
  input  logic           robWe,
  input  logic           regWrite,
  input  logic [REG:0]   destRegR,
  output logic [ROB:0]   destROB,
  output logic           robFull,
  output logic           robEmpty,
  input  logic           cdbValid,
  input  logic [ROB:0]   cdbROB,
  input  logic [WIDTH:0] cdbResult,
  input  logic           cdbMispredict,
  output logic           validCommit,
  output logic [ROB:0]   commitROB,
  output logic [REG:0]   regCommit,
  output logic           commitRegWrite,
  output logic [WIDTH:0] commitResult,
  output logic           reset
);

  localparam int            c_depth = 2 ** (ROB + 1);
  localparam logic [ROB+1:0] c_one  = {{(ROB+1){1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ROB+1:0]     r_head;
  logic [ROB+1:0]     r_tail;
  logic [c_depth-1:0] r_valid;
  logic [c_depth-1:0] r_ready;
  logic [c_depth-1:0] r_regw;
  logic [c_depth-1:0] r_mis;
  logic [REG:0]       r_dest   [c_depth];
  logic [WIDTH:0]     r_result [c_depth];

  logic [ROB:0] w_hidx;
  logic [ROB:0] w_tidx;
  logic         w_full;
  logic         w_byp;
  logic         w_mis;
  logic         w_flush;
  logic         w_alloc;
  logic         w_wb;

  // Status, commit outputs and the enables for this cycle's state updates.
  always_comb begin
    w_hidx   = r_head[ROB:0];
    w_tidx   = r_tail[ROB:0];
    w_full   = (w_hidx == w_tidx) && (r_head[ROB+1] != r_tail[ROB+1]);
    robFull  = w_full;
    robEmpty = (r_head == r_tail);
    destROB  = w_tidx;
    commitROB = w_hidx;
`ifdef ROB_CDB_BYPASS_EN
    w_byp = cdbValid && (cdbROB == w_hidx) && r_valid[w_hidx];
`else
    w_byp = 1'b0;
`endif
    validCommit    = r_valid[w_hidx] && (r_ready[w_hidx] || w_byp);
    regCommit      = r_dest[w_hidx];
    commitRegWrite = r_regw[w_hidx];
    commitResult   = w_byp ? cdbResult : r_result[w_hidx];
    w_mis          = w_byp ? cdbMispredict : r_mis[w_hidx];
    w_flush        = validCommit && w_mis;
    reset          = w_flush;
    // Fullness is judged before this cycle's commit; a flush discards everything.
    w_alloc = robWe && !w_full && !w_flush && !globalReset;
    // The entry being allocated is not yet valid, so allocation wins over a CDB hit.
    w_wb    = cdbValid && r_valid[cdbROB] && !(w_alloc && (cdbROB == w_tidx))
              && !w_flush && !globalReset;
  end

  // Pointers and per-entry status flags.
  always_ff @(posedge clk) begin
    if (globalReset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_ready <= '0;
      r_regw  <= '0;
      r_mis   <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_ready <= '0;
    end else begin
      if (validCommit) begin
        r_valid[w_hidx] <= 1'b0;
        r_head          <= r_head + c_one;
      end
      if (w_alloc) begin
        r_valid[w_tidx] <= 1'b1;
        r_ready[w_tidx] <= 1'b0;
        r_regw[w_tidx]  <= regWrite;
        r_tail          <= r_tail + c_one;
      end
      if (w_wb) begin
        r_ready[cdbROB] <= 1'b1;
        r_mis[cdbROB]   <= cdbMispredict;
      end
    end
  end

  // Payload storage; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_dest[w_tidx] <= regWrite ? destRegR : '0;
    end
    if (w_wb) begin
      r_result[cdbROB] <= cdbResult;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer_commit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_reorder_buffer_commit                                 |
// | Description : Directed scenarios plus random traffic for the reorder   |
// |               buffer, compared each cycle against a queue model.      |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_reorder_buffer_commit;

  logic        clk = 1'b0;
  logic        globalReset = 1'b0;
  logic        robWe = 1'b0;
  logic        regWrite = 1'b0;
  logic [4:0]  destRegR = '0;
  logic [2:0]  destROB;
  logic        robFull;
  logic        robEmpty;
  logic        cdbValid = 1'b0;
  logic [2:0]  cdbROB = '0;
  logic [31:0] cdbResult = '0;
  logic        cdbMispredict = 1'b0;
  logic        validCommit;
  logic [2:0]  commitROB;
  logic [4:0]  regCommit;
  logic        commitRegWrite;
  logic [31:0] commitResult;
  logic        reset;

  always #5 clk = ~clk;

  reorder_buffer_commit #(.ROB(2), .REG(4), .WIDTH(31)) dut (
    .clk            (clk),
    .globalReset    (globalReset),
    .robWe          (robWe),
    .regWrite       (regWrite),
    .destRegR       (destRegR),
    .destROB        (destROB),
    .robFull        (robFull),
    .robEmpty       (robEmpty),
    .cdbValid       (cdbValid),
    .cdbROB         (cdbROB),
    .cdbResult      (cdbResult),
    .cdbMispredict  (cdbMispredict),
    .validCommit    (validCommit),
    .commitROB      (commitROB),
    .regCommit      (regCommit),
    .commitRegWrite (commitRegWrite),
    .commitResult   (commitResult),
    .reset          (reset)
  );

  // Program-order list of in-flight instructions, oldest first.
  typedef struct {
    int        tag;
    bit        regw;
    bit [4:0]  dest;
    bit        ready;
    bit [31:0] result;
    bit        mis;
  } ent_t;

  ent_t mq[$];
  int   m_head = 0;
  int   m_tail = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit byp_hit();
`ifdef ROB_CDB_BYPASS_EN
    return cdbValid && (mq.size() > 0) && (int'(cdbROB) == m_head);
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic model_step();
    int   sz;
    bit   hit;
    bit   vc;
    bit   mis;
    ent_t e;
    if (globalReset) begin
      mq.delete();
      m_head = 0;
      m_tail = 0;
      return;
    end
    sz  = mq.size();
    hit = byp_hit();
    vc  = (sz > 0) && (mq[0].ready || hit);
    mis = hit ? cdbMispredict : ((sz > 0) ? mq[0].mis : 1'b0);
    if (vc && mis) begin
      mq.delete();
      m_head = 0;
      m_tail = 0;
      return;
    end
    if (cdbValid) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].tag == int'(cdbROB)) begin
          e = mq[i];
          e.ready = 1'b1;
          e.result = cdbResult;
          e.mis = cdbMispredict;
          mq[i] = e;
        end
      end
    end
    if (vc) begin
      void'(mq.pop_front());
      m_head = (m_head + 1) % 8;
    end
    if (robWe && sz < 8) begin
      e.tag = m_tail;
      e.regw = regWrite;
      e.dest = regWrite ? destRegR : 5'd0;
      e.ready = 1'b0;
      e.result = 32'd0;
      e.mis = 1'b0;
      mq.push_back(e);
      m_tail = (m_tail + 1) % 8;
    end
  endtask

  // Expected outputs for the current model state and current inputs.
  task automatic compare();
    int   sz;
    bit   hit;
    bit   vc;
    ent_t h;
    sz  = mq.size();
    hit = byp_hit();
    h   = '{0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0};
    if (sz > 0) h = mq[0];
    vc = (sz > 0) && (h.ready || hit);
    chk("robFull", robFull, sz == 8);
    chk("robEmpty", robEmpty, sz == 0);
    chk("destROB", destROB, m_tail);
    chk("commitROB", commitROB, m_head);
    chk("validCommit", validCommit, vc);
    if (vc) begin
      chk("regCommit", regCommit, h.dest);
      chk("commitRegWrite", commitRegWrite, h.regw);
      chk("commitResult", commitResult, hit ? cdbResult : h.result);
      chk("reset", reset, hit ? cdbMispredict : h.mis);
    end else begin
      chk("reset_idle", reset, 1'b0);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (cmp_en) compare();
  end

  task automatic step(input bit we, input bit rw, input int dr, input bit cv,
                      input int ctag, input bit [31:0] cres, input bit cmis, input bit grst);
    @(negedge clk);
    robWe = we;
    regWrite = rw;
    destRegR = dr[4:0];
    cdbValid = cv;
    cdbROB = ctag[2:0];
    cdbResult = cres;
    cdbMispredict = cmis;
    globalReset = grst;
    #3;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 32'd0, 0, 0);
  endtask

  initial begin
    // Reset and fill the buffer.
    step(0, 0, 0, 0, 0, 32'd0, 0, 1);
    cmp_en = 1'b1;
    idle();
    chk("rst_empty", robEmpty, 1'b1);
    chk("rst_full", robFull, 1'b0);
    chk("rst_vc", validCommit, 1'b0);
    chk("rst_reset", reset, 1'b0);
    chk("rst_dest", destROB, 3'd0);
    chk("rst_crob", commitROB, 3'd0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, i + 1, 0, 0, 32'd0, 0, 0);
      chk("alloc_tag", destROB, i[2:0]);
    end
    step(1, 1, 20, 0, 0, 32'd0, 0, 0);
    chk("full_after8", robFull, 1'b1);
    chk("ninth_tail", destROB, 3'd0);

    // Head writeback, then commit while full with an allocation attempt.
`ifdef ROB_CDB_BYPASS_EN
    step(1, 1, 9, 1, 0, 32'hDEADBEEF, 0, 0);
`else
    step(0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0);
    step(1, 1, 9, 0, 0, 32'd0, 0, 0);
`endif
    chk("c0_vc", validCommit, 1'b1);
    chk("c0_rob", commitROB, 3'd0);
    chk("c0_reg", regCommit, 5'd1);
    chk("c0_res", commitResult, 32'hDEADBEEF);
    chk("c0_full", robFull, 1'b1);
    step(1, 1, 9, 0, 0, 32'd0, 0, 0);
    chk("wrap_full", robFull, 1'b0);
    chk("wrap_dest", destROB, 3'd0);

    // Out-of-order writebacks retire in order.
    step(0, 0, 0, 1, 2, 32'h22, 0, 0);
    idle();
    chk("ooo_wait", validCommit, 1'b0);
    step(0, 0, 0, 1, 1, 32'h11, 0, 0);
`ifdef ROB_CDB_BYPASS_EN
    chk("ooo_byp1", commitROB, 3'd1);
    chk("ooo_byp1v", validCommit, 1'b1);
    idle();
    chk("ooo_byp2", commitROB, 3'd2);
    chk("ooo_byp2r", commitResult, 32'h22);
    idle();
`else
    chk("ooo_nocommit", validCommit, 1'b0);
    idle();
    chk("ooo_c1", commitROB, 3'd1);
    chk("ooo_c1r", commitResult, 32'h11);
    idle();
    chk("ooo_c2", commitROB, 3'd2);
    chk("ooo_c2r", commitResult, 32'h22);
`endif

    // Mispredicted head flushes, concurrent alloc/CDB discarded.
`ifdef ROB_CDB_BYPASS_EN
    step(1, 1, 7, 1, 3, 32'h33, 1, 0);
`else
    step(0, 0, 0, 1, 3, 32'h33, 1, 0);
    step(1, 1, 7, 1, 4, 32'h44, 0, 0);
`endif
    chk("flush_reset", reset, 1'b1);
    chk("flush_vc", validCommit, 1'b1);
    chk("flush_rob", commitROB, 3'd3);
    idle();
    chk("post_flush_empty", robEmpty, 1'b1);
    chk("post_flush_dest", destROB, 3'd0);

    // globalReset with entries in flight.
    for (int i = 0; i < 5; i++) step(1, 1, i + 3, 0, 0, 32'd0, 0, 0);
    step(1, 1, 4, 1, 0, 32'h55, 0, 1);
    idle();
    chk("grst_empty", robEmpty, 1'b1);
    chk("grst_vc", validCommit, 1'b0);
    chk("grst_reset", reset, 1'b0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 10) < 6, $urandom % 2, $urandom % 32, $urandom % 2,
           $urandom % 8, $urandom, ($urandom % 16) == 0, ($urandom % 200) == 0);
    end
    idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
